// File: rtl/audio_sample_player_pkg.sv
// audio_player_pkg: shared types and defaults for the audio sample player.
//   state_e    - fetch/play FSM states
//   *_DEF      - default parameter values for the top level
//   VOL_W      - width of the optional volume control (VOLUME_EN builds)
package audio_player_pkg;

  localparam int ADDR_W_DEF = 22;
  localparam int DATA_W_DEF = 8;
  localparam int CPS_DEF    = 6250;  // 50 MHz / 8 kHz
  localparam int VOL_W      = 2;

  typedef enum logic [1:0] {
    FETCH_WAIT = 2'd0,
    REQ        = 2'd1,
    READY      = 2'd2
  } state_e;

endpackage

// File: rtl/audio_sample_player_pwm_dac.sv
// pwm_dac: free-running PWM DAC.
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   level    in   requested duty, DATA_W bits (0 = always low, max = (2^N-1)/2^N)
//   pwm_out  out  registered PWM output
// The level is latched only when the counter wraps, so a level change never
// produces a runt pulse in the middle of a PWM period.
module pwm_dac #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] level,
  output logic              pwm_out
);

  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] lvl_q, lvl_d;
  logic              out_q, out_d;

  // Output is computed from the next counter/level pair so that the first
  // cycle of a new period already uses the freshly latched level.
  always_comb begin
    cnt_d = cnt_q + DATA_W'(1);
    lvl_d = (&cnt_q) ? level : lvl_q;
    out_d = (cnt_d < lvl_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      lvl_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      out_q <= out_d;
    end
  end

  assign pwm_out = out_q;

endmodule

// File: rtl/audio_sample_player.sv
// audio_sample_player: fetches the sample at endereco from sample memory,
// plays it through a PWM DAC at a fixed sample rate and pulses count so the
// address generator advances. Owns the sample-rate timebase.
//   clk, reset         clock, asynchronous active-low reset
//   play               1 = run the sample timer, 0 = pause (output held)
//   endereco           current sample address from the address generator
//   count              1-cycle pulse: sample consumed, advance address
//   mem_req/mem_addr   read request (held until mem_ack) and its address
//   mem_ack/mem_data   1-cycle read completion and data
//   audio_pwm          PWM audio output
//   underrun           sticky: a sample tick found no sample buffered
//   vol (VOLUME_EN)    attenuation shift, 0 = full scale, 3 = 1/8
// Optional feature: define VOLUME_EN to add the vol input.
module audio_sample_player
  import audio_player_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int CLKS_PER_SAMPLE = CPS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [ADDR_W-1:0] endereco,
  output logic              count,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
`ifdef VOLUME_EN
  input  logic [VOL_W-1:0]  vol,
`endif
  output logic              audio_pwm,
  output logic              underrun
);

  localparam int TW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_SAMPLE - 1);

  // ---------------------------------------------------------------- timer
  logic [TW-1:0] timer_q;
  logic          tick;

  assign tick = play && (timer_q == T_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    timer_q <= '0;
    else if (play) timer_q <= (timer_q == T_MAX) ? '0 : timer_q + TW'(1);
  end

  // ------------------------------------------------------------------ FSM
  state_e state_q, state_d;
  logic   load_addr, capture, play_now;
  logic [ADDR_W-1:0] mem_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH_WAIT;
    else        state_q <= state_d;
  end

  // A tick in READY takes priority over a seek: the buffered sample is
  // played, and the refetch after it picks up the new address anyway.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_WAIT: state_d = REQ;
      REQ:        if (mem_ack) state_d = READY;
      READY:      if (tick || (endereco != mem_addr_q)) state_d = FETCH_WAIT;
      default:    state_d = FETCH_WAIT;
    endcase
  end

  // A tick coinciding with mem_ack is still in REQ, so it is an underrun.
  always_comb begin
    mem_req   = (state_q == REQ);
    load_addr = (state_q == FETCH_WAIT);
    capture   = (state_q == REQ) && mem_ack;
    play_now  = (state_q == READY) && tick;
  end

  // ------------------------------------------------------------- datapath
  logic [DATA_W-1:0] buf_q, sample_q;
  logic              count_q, underrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q <= '0;
      buf_q      <= '0;
      sample_q   <= '0;
      count_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (load_addr) mem_addr_q <= endereco;
      if (capture)   buf_q      <= mem_data;
      if (play_now)  sample_q   <= buf_q;
      count_q    <= play_now;
      underrun_q <= underrun_q | (tick && (state_q != READY));
    end
  end

  assign mem_addr = mem_addr_q;
  assign count    = count_q;
  assign underrun = underrun_q;

  // ------------------------------------------------------------- PWM DAC
  logic [DATA_W-1:0] level;

`ifdef VOLUME_EN
  assign level = sample_q >> vol;
`else
  assign level = sample_q;
`endif

  pwm_dac #(.DATA_W(DATA_W)) u_pwm (
    .clk     (clk),
    .reset   (reset),
    .level   (level),
    .pwm_out (audio_pwm)
  );

endmodule

// File: tb/tb_audio_sample_player.sv
module tb_audio_sample_player;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 8;
  localparam int CPS    = 300;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              play = 1'b0;
  logic [ADDR_W-1:0] endereco = '0;
  logic              count;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              audio_pwm;
  logic              underrun;
`ifdef VOLUME_EN
  logic [1:0]        vol = 2'd0;
`endif

  int tests = 0;
  int fails = 0;
  int ack_delay = 3;

  always #5 clk = ~clk;

  audio_sample_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLKS_PER_SAMPLE(CPS)) dut (
    .clk(clk), .reset(reset), .play(play), .endereco(endereco), .count(count),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
`ifdef VOLUME_EN
    .vol(vol),
`endif
    .audio_pwm(audio_pwm), .underrun(underrun)
  );

  // Memory model: ack ack_delay cycles after mem_req rises, data = addr[7:0].
  int req_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ack  <= 1'b0;
      mem_data <= '0;
      req_cnt  <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (req_cnt >= ack_delay - 1) begin
          mem_ack  <= 1'b1;
          mem_data <= mem_addr[7:0];
          req_cnt  <= 0;
        end else begin
          req_cnt <= req_cnt + 1;
        end
      end else begin
        req_cnt <= 0;
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Waits (bounded) for the next count pulse; returns at the negedge it is seen.
  task automatic wait_count(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (count) begin ok = 1'b1; break; end
    end
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (count) n++;
    end
  endtask

  task automatic measure_high(output int n);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (audio_pwm) n++;
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                exp_high;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit ok;
    int n;

    vecs[0] = '{addr: 22'd0,   exp_high: 0};
    vecs[1] = '{addr: 22'd128, exp_high: 128};
    vecs[2] = '{addr: 22'd255, exp_high: 255};
    vecs[3] = '{addr: 22'd200, exp_high: 200};

    // ---- reset state
    play = 1'b1;
    endereco = 22'd5;
    repeat (3) @(negedge clk);
    check("rst count", count, 0);
    check("rst mem_req", mem_req, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst audio_pwm", audio_pwm, 0);
    check("rst underrun", underrun, 0);

    // ---- first fetch and first tick
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("first mem_req", mem_req, 1);
    check("first mem_addr", mem_addr, 5);
    wait_count(700, ok);
    check("first count seen", ok, 1);
    @(negedge clk);
    check("count one cycle", count, 0);
    check("no underrun", underrun, 0);
    repeat (260) @(negedge clk);
    measure_high(n);
    check("duty sample 5", n, 5);

    // ---- seek while READY
    endereco = 22'd1605;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("seek mem_req", mem_req, 1);
    check("seek mem_addr", mem_addr, 1605);
    count_pulses(300, n);
    check("seek one count", n, 1);
    repeat (260) @(negedge clk);
    measure_high(n);
    check("duty seek 0x45", n, 69);

    // ---- PWM duty table
    foreach (vecs[i]) begin
      endereco = vecs[i].addr;
      wait_count(700, ok);
      check("table count a", ok, 1);
      wait_count(700, ok);
      check("table count b", ok, 1);
      repeat (260) @(negedge clk);
      measure_high(n);
      check($sformatf("duty addr %0d", vecs[i].addr), n, vecs[i].exp_high);
    end

    // ---- pause
    play = 1'b0;
    count_pulses(1000, n);
    check("pause no count", n, 0);
    measure_high(n);
    check("pause duty held", n, 200);
    play = 1'b1;
    wait_count(400, ok);
    check("resume count", ok, 1);

    // ---- underrun: slow memory, tick lands in REQ
    check("pre underrun", underrun, 0);
    ack_delay = 400;
    count_pulses(350, n);
    check("underrun no count", n, 0);
    check("underrun set", underrun, 1);
    measure_high(n);
    check("underrun duty held", n, 200);
    ack_delay = 3;
    repeat (700) @(negedge clk);
    check("underrun sticky", underrun, 1);

`ifdef VOLUME_EN
    vol = 2'd2;
    repeat (260) @(negedge clk);
    measure_high(n);
    check("vol2 duty", n, 50);
    vol = 2'd0;
`endif

    // ---- async reset in the middle of a request
    ack_delay = 50;
    wait_count(700, ok);
    check("pre-reset count", ok, 1);
    repeat (5) @(negedge clk);
    check("mid REQ mem_req", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("areset mem_req", mem_req, 0);
    check("areset mem_addr", mem_addr, 0);
    check("areset count", count, 0);
    check("areset underrun", underrun, 0);
    check("areset audio_pwm", audio_pwm, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
